// File: rtl/image_uart_dumper.sv
// Purpose : streams data memory bytes 0..DEPTH-1 out on a UART TX line as 8N1, LSB first, after a start pulse.
// Latency : first start bit appears 3 cycles after start is sampled; each byte takes 10*CLKS_PER_BIT+2 cycles.
// Backpres: none; start is ignored while a dump is in progress, and the memory read port is always ready.
// Ports   : clk/rst (sync, active-high) | start (dump request pulse) | mem_addr/mem_rdata (sync-read memory,
//           data valid one cycle after address) | tx (serial out, idles high) | busy (dump running) | done (end pulse)
module image_uart_dumper #(
  parameter int DEPTH        = 16384,
  parameter int ADDR_W       = 14,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  // Baud counter keeps at least one bit so CLKS_PER_BIT=1 still elaborates;
  // in that case the counter sits at 0 and every cycle is terminal.
  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr,  w_addr_next;
  logic [7:0]        r_shift, w_shift_next;
  logic [2:0]        r_bit,   w_bit_next;
  logic [BAUD_W-1:0] r_baud,  w_baud_next;
  logic              r_tx,    w_tx_next;
  logic              r_done,  w_done_next;
  logic              w_baud_last;

  assign w_baud_last = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_baud_next  = r_baud;
    w_done_next  = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_addr_next  = '0;
        end
      end

      // Address is already on mem_addr; read data shows up during WAIT.
      S_FETCH: begin
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        w_shift_next = mem_rdata;
        w_bit_next   = '0;
        w_baud_next  = '0;
        w_state_next = S_START;
      end

      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_next   = '0;
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          // Last byte: stop without incrementing, so the address never
          // passes DEPTH-1 even when DEPTH fills the whole address space.
          if (r_addr == ADDR_LAST) begin
            w_done_next  = 1'b1;
            w_addr_next  = '0;
            w_state_next = S_IDLE;
          end else begin
            w_addr_next  = r_addr + 1'b1;
            w_state_next = S_FETCH;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // tx is registered from the next state so the line changes exactly on
    // state boundaries and never glitches.
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      r_baud  <= w_baud_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  assign mem_addr = r_addr;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_image_uart_dumper.sv
// Bench for image_uart_dumper: three instances (4-byte/4-clk, 1-byte/4-clk, 4-byte/1-clk on a 2-bit address).
// Bytes are pushed to a scoreboard queue when a dump is launched and popped by a cycle-based UART receiver.
module tb_image_uart_dumper;

  logic        clk;
  logic        rst;
  logic        start_a, start_b, start_c;
  logic [13:0] addr_a, addr_b;
  logic [1:0]  addr_c;
  logic [7:0]  rdata_a, rdata_b, rdata_c;
  logic        tx_a, tx_b, tx_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b;
  logic [7:0]  mem_c [4];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  sb_q [$];

  image_uart_dumper #(.DEPTH(4), .ADDR_W(14), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  image_uart_dumper #(.DEPTH(1), .ADDR_W(14), .CLKS_PER_BIT(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  image_uart_dumper #(.DEPTH(4), .ADDR_W(2), .CLKS_PER_BIT(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .mem_addr(addr_c), .mem_rdata(rdata_c),
    .tx(tx_c), .busy(busy_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data valid the cycle after the address.
  always @(posedge clk) begin
    rdata_a <= mem_a[addr_a[1:0]];
    rdata_b <= mem_b;
    rdata_c <= mem_c[addr_c];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic g_tx(input int sel);
    return (sel == 0) ? tx_a : tx_c;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel == 0) ? busy_a : busy_c;
  endfunction
  function automatic logic g_done(input int sel);
    return (sel == 0) ? done_a : done_c;
  endfunction
  function automatic logic [31:0] g_addr(input int sel);
    return (sel == 0) ? 32'(addr_a) : 32'(addr_c);
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_c = v;
  endtask

  // Launches a 4-byte dump on instance sel and decodes the tx line cycle by cycle.
  // t counts cycles with t=1 the first FETCH cycle; samples are taken on negedges.
  task automatic run_dump(input int sel, input logic [31:0] img, input int cpb,
                          input int exp_done_t, input bit pester);
    int         t, c, k, ndone, done_t, max_addr, last_sof;
    bit         rx_on;
    logic [7:0] sh, exp_b;
    sh = '0;
    c  = 0;
    for (int i = 0; i < 4; i++) begin
      if (sel == 0) mem_a[i] = img[8*i +: 8];
      else          mem_c[i] = img[8*i +: 8];
      sb_q.push_back(img[8*i +: 8]);
    end
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    t = 1;
    chk("first_fetch_busy", 32'(g_busy(sel)), 1);
    chk("first_fetch_addr", g_addr(sel), 0);
    rx_on = 0; ndone = 0; done_t = -1; max_addr = 0; last_sof = -1;
    while (t <= exp_done_t + 20) begin
      if (g_done(sel) === 1'b1) begin
        ndone++;
        if (done_t < 0) done_t = t;
      end
      if (int'(g_addr(sel)) > max_addr) max_addr = int'(g_addr(sel));
      if (!rx_on && g_tx(sel) === 1'b0) begin
        rx_on = 1;
        c = 0;
        if (last_sof >= 0) chk("byte_period", 32'(t - last_sof), 32'(10*cpb + 2));
        last_sof = t;
      end
      if (rx_on) begin
        if (c >= cpb/2 && ((c - cpb/2) % cpb) == 0) begin
          k = (c - cpb/2) / cpb;
          if (k == 0) chk("rx_start_bit", 32'(g_tx(sel)), 0);
          else if (k <= 8) sh[k-1] = g_tx(sel);
          else begin
            chk("rx_stop_bit", 32'(g_tx(sel)), 1);
            rx_on = 0;
            if (sb_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL rx_unexpected_byte: got %0h expected no byte", sh);
            end else begin
              exp_b = sb_q.pop_front();
              chk("rx_byte", 32'(sh), 32'(exp_b));
            end
          end
        end
        c++;
      end
      // Re-pulse start mid-DATA of byte 1 and on the edge that raises done.
      if (pester && (t == 60 || t == exp_done_t - 1)) set_start(sel, 1'b1);
      else                                             set_start(sel, 1'b0);
      @(negedge clk);
      t++;
    end
    set_start(sel, 1'b0);
    chk("done_count", 32'(ndone), 1);
    chk("done_time", 32'(done_t), 32'(exp_done_t));
    chk("max_addr", 32'(max_addr), 3);
    chk("sb_empty", 32'(sb_q.size()), 0);
    chk("idle_after", 32'(g_busy(sel)), 0);
    sb_q.delete();
  endtask

  typedef struct {
    int          sel;
    int          cpb;
    logic [31:0] img;
    int          exp_done_t;
    bit          pester;
  } vec_t;

  initial begin
    vec_t       vecs [4];
    logic [9:0] frame;
    logic       exp_tx;
    int         nd;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [4];
    logic [9:0] frame;
    logic       exp_tx;
    int         nd;

    // done at first FETCH (t=1) + DEPTH*(10*CLKS_PER_BIT+2)
    vecs[0] = '{0, 4, 32'h81_3C_FF_00, 169, 1'b0};
    vecs[1] = '{0, 4, 32'h01_80_5A_A5, 169, 1'b1};
    vecs[2] = '{2, 1, 32'h81_3C_FF_00, 49,  1'b0};
    vecs[3] = '{2, 1, 32'hA5_5A_C3_0F, 49,  1'b0};

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = '0;
      mem_c[i] = '0;
    end
    mem_b = '0;

    // Reset with start held high: nothing may start.
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 1);     chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0); chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_tx_b", 32'(tx_b), 1);     chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_done_b", 32'(done_b), 0); chk("rst_addr_b", 32'(addr_b), 0);
    chk("rst_tx_c", 32'(tx_c), 1);     chk("rst_busy_c", 32'(busy_c), 0);
    chk("rst_done_c", 32'(done_c), 0); chk("rst_addr_c", 32'(addr_c), 0);
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_a", 32'(busy_a), 0);
    chk("post_rst_idle_c", 32'(busy_c), 0);

    // Single byte 0xA5 on the DEPTH=1 instance, exact cycle-by-cycle waveform.
    mem_b = 8'hA5;
    frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int t = 1; t <= 46; t++) begin
      exp_tx = (t >= 3 && t <= 42) ? frame[(t-3)/4] : 1'b1;
      chk("single_tx",   32'(tx_b),   32'(exp_tx));
      chk("single_busy", 32'(busy_b), (t <= 42) ? 32'd1 : 32'd0);
      chk("single_done", 32'(done_b), (t == 43) ? 32'd1 : 32'd0);
      chk("single_addr", 32'(addr_b), 0);
      @(negedge clk);
    end

    // Table of dumps: ordering, start-while-busy, CLKS_PER_BIT=1 boundary.
    for (int v = 0; v < 4; v++)
      run_dump(vecs[v].sel, vecs[v].img, vecs[v].cpb, vecs[v].exp_done_t, vecs[v].pester);

    // Reset during DATA bit 3 of byte 2 (byte 0xC3, bit 3 is 0).
    mem_a[0] = 8'hA5; mem_a[1] = 8'h0F; mem_a[2] = 8'hC3; mem_a[3] = 8'h5A;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (103) @(negedge clk);
    chk("abort_pre_tx",   32'(tx_a),   0);
    chk("abort_pre_busy", 32'(busy_a), 1);
    chk("abort_pre_addr", 32'(addr_a), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx",   32'(tx_a),   1);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_done", 32'(done_a), 0);
    chk("abort_addr", 32'(addr_a), 0);
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    chk("abort_idle",    32'(busy_a), 0);

    // A fresh start after the abort dumps again from address 0.
    run_dump(0, 32'h5A_C3_0F_A5, 4, 169, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
